// File: rtl/id_ex_pkg.sv
// Shared definitions for the ID/EX pipeline register: control bundle layout,
// register-address width and the per-edge update selection.
package id_ex_pkg;

    localparam int CTRL_W     = 8;
    localparam int REG_ADDR_W = 5;

    // Control bundle bit positions, shared with ID decode and EX.
    localparam int CTRL_REGWRITE  = 0;
    localparam int CTRL_MEMTOREG  = 1;
    localparam int CTRL_MEMREAD   = 2;
    localparam int CTRL_MEMWRITE  = 3;
    localparam int CTRL_ALUSRC    = 4;
    localparam int CTRL_REGDST    = 5;
    localparam int CTRL_ALUOP_LSB = 6;
    localparam int CTRL_ALUOP_MSB = 7;

    typedef logic [CTRL_W-1:0]     ctrl_t;
    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    // An all-zero bundle is a no-op: no writes, no memory access.
    localparam ctrl_t CTRL_BUBBLE = '0;

    // What the pipeline register does on the next (non-reset) edge.
    typedef enum logic [1:0] {
        UPD_HOLD   = 2'd0,
        UPD_FLUSH  = 2'd1,
        UPD_BUBBLE = 2'd2,
        UPD_LOAD   = 2'd3
    } upd_sel_e;

    function automatic logic ctrl_memread(input ctrl_t c);
        return c[CTRL_MEMREAD];
    endfunction

endpackage

// File: rtl/id_ex_stage_hazard_detect.sv
// Load-use hazard compare: the instruction in EX is a load whose destination
// (RT, non-zero) is a source of the instruction currently in ID.
module hazard_detect
    import id_ex_pkg::*;
(
    input  logic      ex_memread,
    input  reg_addr_t ex_rt,
    input  reg_addr_t id_rs,
    input  reg_addr_t id_rt,
    output logic      hazard
);

    logic [REG_ADDR_W-1:0] rs_bit_eq;
    logic [REG_ADDR_W-1:0] rt_bit_eq;

    // Bitwise equality so the compare maps to one LUT level per bit.
    for (genvar gi = 0; gi < REG_ADDR_W; gi++) begin : g_cmp
        assign rs_bit_eq[gi] = ~(ex_rt[gi] ^ id_rs[gi]);
        assign rt_bit_eq[gi] = ~(ex_rt[gi] ^ id_rt[gi]);
    end

    logic rs_match;
    logic rt_match;
    logic rt_nonzero;

    assign rs_match   = &rs_bit_eq;
    assign rt_match   = &rt_bit_eq;
    // Loads into $0 are discarded, so they can never cause a dependency.
    assign rt_nonzero = |ex_rt;

    assign hazard = ex_memread & rt_nonzero & (rs_match | rt_match);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, flush handling
// that survives a downstream hold, and a saturating bubble counter.
module id_ex_stage
    import id_ex_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [7:0]        ctrl_i,
    input  logic [DATA_W-1:0] RSdata_i,
    input  logic [DATA_W-1:0] RTdata_i,
    input  logic [DATA_W-1:0] imm_i,
    input  logic [4:0]        IF_ID_RS_i,
    input  logic [4:0]        IF_ID_RT_i,
    input  logic [4:0]        IF_ID_RD_i,
    input  logic              flush_i,
    input  logic              hold_i,
    output logic [7:0]        ID_EX_ctrl_o,
    output logic [DATA_W-1:0] ID_EX_RSdata_o,
    output logic [DATA_W-1:0] ID_EX_RTdata_o,
    output logic [DATA_W-1:0] ID_EX_imm_o,
    output logic [4:0]        ID_EX_RS_o,
    output logic [4:0]        ID_EX_RT_o,
    output logic [4:0]        ID_EX_RD_o,
    output logic              stall_o,
    output logic [CNT_W-1:0]  stall_cnt_o
);

    localparam int NUM_OPND = 3;

    ctrl_t             ctrl_reg,       ctrl_next;
    reg_addr_t         rs_reg,         rs_next;
    reg_addr_t         rt_reg,         rt_next;
    reg_addr_t         rd_reg,         rd_next;
    logic              flush_pend_reg, flush_pend_next;
    logic [CNT_W-1:0]  stall_cnt_reg,  stall_cnt_next;

    // Operand data (RS, RT, immediate) handled uniformly as a small array.
    logic [DATA_W-1:0] opnd_in   [NUM_OPND];
    logic [DATA_W-1:0] opnd_reg  [NUM_OPND];
    logic [DATA_W-1:0] opnd_next [NUM_OPND];

    logic     hazard;
    logic     flush_eff;
    logic     cnt_at_max;
    upd_sel_e upd_sel;

    assign opnd_in[0] = RSdata_i;
    assign opnd_in[1] = RTdata_i;
    assign opnd_in[2] = imm_i;

    hazard_detect u_hazard_detect (
        .ex_memread (ctrl_memread(ctrl_reg)),
        .ex_rt      (rt_reg),
        .id_rs      (IF_ID_RS_i),
        .id_rt      (IF_ID_RT_i),
        .hazard     (hazard)
    );

    // A flush seen during a hold is remembered until the pipe can move.
    assign flush_eff  = flush_i | flush_pend_reg;
    assign cnt_at_max = &stall_cnt_reg;

    // Stall the front end on a load-use dependency or any downstream hold.
    assign stall_o = hazard | hold_i;

    // Pick this edge's update: hold beats flush, flush beats hazard.
    always_comb begin
        upd_sel = UPD_LOAD;
        if (hold_i) begin
            upd_sel = UPD_HOLD;
        end else if (flush_eff) begin
            upd_sel = UPD_FLUSH;
        end else if (hazard) begin
            upd_sel = UPD_BUBBLE;
        end
    end

    // Next-state for control, addresses, pending flush and bubble counter.
    always_comb begin
        ctrl_next       = ctrl_reg;
        rs_next         = rs_reg;
        rt_next         = rt_reg;
        rd_next         = rd_reg;
        flush_pend_next = flush_pend_reg;
        stall_cnt_next  = stall_cnt_reg;
        case (upd_sel)
            UPD_HOLD: begin
                flush_pend_next = flush_pend_reg | flush_i;
            end
            UPD_FLUSH: begin
                ctrl_next       = CTRL_BUBBLE;
                rs_next         = IF_ID_RS_i;
                rt_next         = IF_ID_RT_i;
                rd_next         = IF_ID_RD_i;
                flush_pend_next = 1'b0;
            end
            UPD_BUBBLE: begin
                // The bubble clears memread, so the hazard drops next cycle.
                ctrl_next       = CTRL_BUBBLE;
                rs_next         = IF_ID_RS_i;
                rt_next         = IF_ID_RT_i;
                rd_next         = IF_ID_RD_i;
                flush_pend_next = 1'b0;
                stall_cnt_next  = cnt_at_max ? stall_cnt_reg
                                             : stall_cnt_reg + CNT_W'(1);
            end
            default: begin
                ctrl_next       = ctrl_i;
                rs_next         = IF_ID_RS_i;
                rt_next         = IF_ID_RT_i;
                rd_next         = IF_ID_RD_i;
                flush_pend_next = 1'b0;
            end
        endcase
    end

    // Operand data loads on every moving edge; only a hold freezes it.
    for (genvar gi = 0; gi < NUM_OPND; gi++) begin : g_opnd
        always_comb begin
            opnd_next[gi] = (upd_sel == UPD_HOLD) ? opnd_reg[gi] : opnd_in[gi];
        end

        // Operand register with synchronous active-low clear.
        always_ff @(posedge clk_i) begin
            if (!rst_i) begin
                opnd_reg[gi] <= '0;
            end else begin
                opnd_reg[gi] <= opnd_next[gi];
            end
        end
    end

    // Control/address/flush/counter state; reset discards any pending flush.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            ctrl_reg       <= '0;
            rs_reg         <= '0;
            rt_reg         <= '0;
            rd_reg         <= '0;
            flush_pend_reg <= 1'b0;
            stall_cnt_reg  <= '0;
        end else begin
            ctrl_reg       <= ctrl_next;
            rs_reg         <= rs_next;
            rt_reg         <= rt_next;
            rd_reg         <= rd_next;
            flush_pend_reg <= flush_pend_next;
            stall_cnt_reg  <= stall_cnt_next;
        end
    end

    assign ID_EX_ctrl_o   = ctrl_reg;
    assign ID_EX_RS_o     = rs_reg;
    assign ID_EX_RT_o     = rt_reg;
    assign ID_EX_RD_o     = rd_reg;
    assign ID_EX_RSdata_o = opnd_reg[0];
    assign ID_EX_RTdata_o = opnd_reg[1];
    assign ID_EX_imm_o    = opnd_reg[2];
    assign stall_cnt_o    = stall_cnt_reg;

endmodule
